// File: rtl/rv32i_mc_control_pkg.sv
// Shared types for the RV32I multi-cycle control path: mnemonics, registers, FSM states,
// datapath select encodings and the mnemonic classifier used by the controller.
package rv32i_mc_control_pkg;

  typedef enum logic [5:0] {
    NULL, LUI, AUIPC, JAL, JALR,
    BEQ, BNE, BLT, BGE, BLTU, BGEU,
    LB, LH, LW, LBU, LHU,
    SB, SH, SW,
    ADDI, SLTI, SLTIU, XORI, ORI, ANDI, SLLI, SRLI, SRAI,
    ADD, SUB, SLL, SLT, SLTU, XOR, SRL, SRA, OR, AND,
    ECALL, EBREAK
  } RV32I_INSTRUCTION_MNEMONIC_t;

  typedef enum logic [4:0] {
    ZERO, RA, SP, GP, TP, T0, T1, T2, S0, S1,
    A0, A1, A2, A3, A4, A5, A6, A7,
    S2, S3, S4, S5, S6, S7, S8, S9, S10, S11,
    T3, T4, T5, T6
  } RV32I_REGISTER_t;

  typedef enum logic [2:0] {
    ST_FETCH  = 3'd0,
    ST_DECODE = 3'd1,
    ST_EXEC   = 3'd2,
    ST_MEM    = 3'd3,
    ST_WB     = 3'd4,
    ST_TRAP   = 3'd5
  } RV32I_MC_STATE_t;

  typedef enum logic [1:0] {PC_PLUS4, PC_IMM, PC_JALR} RV32I_PC_SEL_t;
  typedef enum logic [1:0] {WB_ALU, WB_MEM, WB_PC4, WB_IMM} RV32I_WB_SEL_t;
  typedef enum logic [1:0] {MSZ_BYTE, MSZ_HALF, MSZ_WORD} RV32I_MEM_SIZE_t;
  typedef enum logic [1:0] {TC_NONE, TC_ECALL, TC_EBREAK, TC_ILLEGAL} RV32I_TRAP_CAUSE_t;

  typedef enum logic [3:0] {
    CL_ALU_R, CL_ALU_I, CL_LOAD, CL_STORE, CL_BRANCH,
    CL_JUMP, CL_UPPER, CL_SYSTEM, CL_ILLEGAL
  } RV32I_MC_CLASS_t;

  function automatic RV32I_MC_CLASS_t mnemonic_class(input RV32I_INSTRUCTION_MNEMONIC_t mn);
    case (mn)
      ADD, SUB, SLL, SLT, SLTU, XOR, SRL, SRA, OR, AND:       return CL_ALU_R;
      ADDI, SLTI, SLTIU, XORI, ORI, ANDI, SLLI, SRLI, SRAI:   return CL_ALU_I;
      LB, LH, LW, LBU, LHU:                                   return CL_LOAD;
      SB, SH, SW:                                             return CL_STORE;
      BEQ, BNE, BLT, BGE, BLTU, BGEU:                         return CL_BRANCH;
      JAL, JALR:                                              return CL_JUMP;
      LUI, AUIPC:                                             return CL_UPPER;
      ECALL, EBREAK:                                          return CL_SYSTEM;
      default:                                                return CL_ILLEGAL;
    endcase
  endfunction

  function automatic RV32I_MEM_SIZE_t mem_size_of(input RV32I_INSTRUCTION_MNEMONIC_t mn);
    case (mn)
      LB, LBU, SB: return MSZ_BYTE;
      LH, LHU, SH: return MSZ_HALF;
      default:     return MSZ_WORD;
    endcase
  endfunction

endpackage

// File: rtl/rv32i_mem_timeout.sv
// Counts stalled memory-request cycles and flags the cycle on which the wait budget runs out.
// MEM_TIMEOUT of 0 disables expiry; a ready arriving on the last allowed cycle suppresses it.
module rv32i_mem_timeout #(
  parameter int unsigned MEM_TIMEOUT = 16
) (
  input  logic clk,
  input  logic rst_n,
  input  logic req_i,
  input  logic ready_i,
  output logic expired_o
);

  localparam int unsigned CW = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT) : 1;
  localparam logic [CW-1:0] LAST = CW'(MEM_TIMEOUT - 1);

  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;

  // Dropping req means the controller left FETCH/MEM, so the budget restarts there too.
  always_comb begin
    cnt_d = cnt_q;
    if (!req_i || ready_i) begin
      cnt_d = '0;
    end else begin
      cnt_d = cnt_q + CW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign expired_o = (MEM_TIMEOUT != 0) && req_i && !ready_i && (cnt_q == LAST);

endmodule

// File: rtl/rv32i_mc_control.sv
// Multi-cycle RV32I control FSM: fetch/decode/exec/mem/wb over one shared memory port.
// Optional RV32I_MC_CTRL_PERF_EN adds cycle_cnt/instret_cnt performance counters.
module rv32i_mc_control
  import rv32i_mc_control_pkg::*;
#(
  parameter int unsigned MEM_TIMEOUT = 16
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  RV32I_INSTRUCTION_MNEMONIC_t mnemonic,
  input  RV32I_REGISTER_t             rd_addr,
  input  logic                        br_taken,
  input  logic                        mem_ready,
  output logic                        ir_we,
  output logic                        pc_we,
  output logic [1:0]                  pc_sel,
  output logic                        mem_req,
  output logic                        mem_we,
  output logic [1:0]                  mem_size,
  output logic                        mem_unsigned,
  output logic                        addr_sel,
  output logic                        alu_a_sel,
  output logic                        alu_b_sel,
  output logic [1:0]                  wb_sel,
  output logic                        rf_we,
  output logic                        trap,
  output logic [1:0]                  trap_cause,
  output logic [2:0]                  state
`ifdef RV32I_MC_CTRL_PERF_EN
  ,
  output logic [31:0]                 cycle_cnt,
  output logic [31:0]                 instret_cnt
`endif
);

  RV32I_MC_STATE_t   state_q, state_d;
  RV32I_TRAP_CAUSE_t cause_q, cause_d;
  logic              trap_q;
  RV32I_MC_CLASS_t   cls;
  logic              tmo_expired;

  assign cls = mnemonic_class(mnemonic);

  rv32i_mem_timeout #(
    .MEM_TIMEOUT(MEM_TIMEOUT)
  ) u_mem_timeout (
    .clk      (clk),
    .rst_n    (rst_n),
    .req_i    (mem_req),
    .ready_i  (mem_ready),
    .expired_o(tmo_expired)
  );

  always_comb begin
    state_d      = state_q;
    cause_d      = cause_q;
    ir_we        = 1'b0;
    pc_we        = 1'b0;
    pc_sel       = PC_PLUS4;
    mem_req      = 1'b0;
    mem_we       = 1'b0;
    mem_size     = MSZ_BYTE;
    mem_unsigned = 1'b0;
    addr_sel     = 1'b0;
    alu_a_sel    = 1'b0;
    alu_b_sel    = 1'b0;
    wb_sel       = WB_ALU;
    rf_we        = 1'b0;

    case (state_q)
      ST_FETCH: begin
        mem_req  = 1'b1;
        mem_size = MSZ_WORD;
        if (mem_ready) begin
          ir_we   = 1'b1;
          state_d = ST_DECODE;
        end else if (tmo_expired) begin
          state_d = ST_TRAP;
          cause_d = TC_ILLEGAL;
        end
      end

      ST_DECODE: state_d = ST_EXEC;

      ST_EXEC: begin
        case (cls)
          CL_ALU_R: state_d = ST_WB;
          CL_ALU_I: begin
            alu_b_sel = 1'b1;
            state_d   = ST_WB;
          end
          CL_LOAD, CL_STORE: begin
            alu_b_sel = 1'b1;
            state_d   = ST_MEM;
          end
          CL_UPPER: begin
            if (mnemonic == AUIPC) begin
              alu_a_sel = 1'b1;
              alu_b_sel = 1'b1;
            end
            state_d = ST_WB;
          end
          CL_BRANCH: begin
            pc_we   = 1'b1;
            pc_sel  = br_taken ? PC_IMM : PC_PLUS4;
            state_d = ST_FETCH;
          end
          CL_JUMP: begin
            pc_sel  = (mnemonic == JALR) ? PC_JALR : PC_IMM;
            state_d = ST_WB;
          end
          CL_SYSTEM: begin
            state_d = ST_TRAP;
            cause_d = (mnemonic == ECALL) ? TC_ECALL : TC_EBREAK;
          end
          default: begin
            state_d = ST_TRAP;
            cause_d = TC_ILLEGAL;
          end
        endcase
      end

      ST_MEM: begin
        mem_req      = 1'b1;
        addr_sel     = 1'b1;
        mem_we       = (cls == CL_STORE);
        mem_size     = mem_size_of(mnemonic);
        mem_unsigned = (mnemonic == LBU) || (mnemonic == LHU);
        if (mem_ready) begin
          if (cls == CL_STORE) begin
            pc_we   = 1'b1;
            state_d = ST_FETCH;
          end else begin
            state_d = ST_WB;
          end
        end else if (tmo_expired) begin
          state_d = ST_TRAP;
          cause_d = TC_ILLEGAL;
        end
      end

      ST_WB: begin
        rf_we = (rd_addr != ZERO);
        pc_we = 1'b1;
        case (cls)
          CL_LOAD: wb_sel = WB_MEM;
          CL_JUMP: begin
            wb_sel = WB_PC4;
            pc_sel = (mnemonic == JALR) ? PC_JALR : PC_IMM;
          end
          CL_UPPER: wb_sel = (mnemonic == LUI) ? WB_IMM : WB_ALU;
          default:  wb_sel = WB_ALU;
        endcase
        state_d = ST_FETCH;
      end

      ST_TRAP: state_d = ST_TRAP;

      default: state_d = ST_FETCH;
    endcase
  end

  // trap is registered alongside the state so it is high exactly while the FSM sits in TRAP.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_FETCH;
      cause_q <= TC_NONE;
      trap_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cause_q <= cause_d;
      trap_q  <= (state_d == ST_TRAP);
    end
  end

  assign trap       = trap_q;
  assign trap_cause = cause_q;
  assign state      = state_q;

`ifdef RV32I_MC_CTRL_PERF_EN
  logic [31:0] cycle_cnt_q;
  logic [31:0] instret_cnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cycle_cnt_q   <= '0;
      instret_cnt_q <= '0;
    end else begin
      if (state_q != ST_TRAP) cycle_cnt_q <= cycle_cnt_q + 32'd1;
      if (pc_we) instret_cnt_q <= instret_cnt_q + 32'd1;
    end
  end

  assign cycle_cnt   = cycle_cnt_q;
  assign instret_cnt = instret_cnt_q;
`endif

endmodule

// File: tb/tb_rv32i_mc_control.sv
// Random + directed instruction streams checked cycle by cycle against a phase-level model.
module tb_rv32i_mc_control;
  import rv32i_mc_control_pkg::*;

  localparam int TMO = 4;

  logic                        clk;
  logic                        rst_n;
  RV32I_INSTRUCTION_MNEMONIC_t mnemonic;
  RV32I_REGISTER_t             rd_addr;
  logic                        br_taken;
  logic                        mem_ready;
  logic                        ir_we, pc_we, mem_req, mem_we, mem_unsigned;
  logic                        addr_sel, alu_a_sel, alu_b_sel, rf_we, trap;
  logic [1:0]                  pc_sel, mem_size, wb_sel, trap_cause;
  logic [2:0]                  state;
`ifdef RV32I_MC_CTRL_PERF_EN
  logic [31:0]                 cycle_cnt, instret_cnt;
  int                          exp_instret = 0;
`endif

  typedef struct packed {
    logic       ir_we;
    logic       pc_we;
    logic [1:0] pc_sel;
    logic       mem_req;
    logic       mem_we;
    logic [1:0] mem_size;
    logic       mem_unsigned;
    logic       addr_sel;
    logic       alu_a_sel;
    logic       alu_b_sel;
    logic [1:0] wb_sel;
    logic       rf_we;
    logic       trap;
    logic [1:0] trap_cause;
    logic [2:0] state;
  } outs_t;

  int vectors = 0;
  int miscompares = 0;

  rv32i_mc_control #(.MEM_TIMEOUT(TMO)) dut (
    .clk(clk), .rst_n(rst_n), .mnemonic(mnemonic), .rd_addr(rd_addr),
    .br_taken(br_taken), .mem_ready(mem_ready), .ir_we(ir_we), .pc_we(pc_we),
    .pc_sel(pc_sel), .mem_req(mem_req), .mem_we(mem_we), .mem_size(mem_size),
    .mem_unsigned(mem_unsigned), .addr_sel(addr_sel), .alu_a_sel(alu_a_sel),
    .alu_b_sel(alu_b_sel), .wb_sel(wb_sel), .rf_we(rf_we), .trap(trap),
    .trap_cause(trap_cause), .state(state)
`ifdef RV32I_MC_CTRL_PERF_EN
    , .cycle_cnt(cycle_cnt), .instret_cnt(instret_cnt)
`endif
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout required completion");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic outs_t observed();
    outs_t o;
    o = '{ir_we, pc_we, pc_sel, mem_req, mem_we, mem_size, mem_unsigned, addr_sel,
          alu_a_sel, alu_b_sel, wb_sel, rf_we, trap, trap_cause, state};
    return o;
  endfunction

  function automatic logic rbit();
    return 1'($urandom_range(0, 1));
  endfunction

  function automatic outs_t fetch_vec();
    outs_t e;
    e = '0;
    e.mem_req  = 1'b1;
    e.mem_size = 2'd2;
    return e;
  endfunction

  // One clock: drive ready, compare outputs mid-cycle, advance to the next falling edge.
  task automatic cyc(input string tag, input logic rdy, input outs_t e);
    mem_ready = rdy;
    #1;
    check(tag, {11'b0, observed()}, {11'b0, e});
`ifdef RV32I_MC_CTRL_PERF_EN
    if (e.pc_we) exp_instret++;
`endif
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic expect_trap(input logic [1:0] cause, input int hold);
    outs_t e;
    e = '0;
    e.trap       = 1'b1;
    e.trap_cause = cause;
    e.state      = 3'd5;
    for (int i = 0; i < hold; i++) cyc("trap_hold", rbit(), e);
    mem_ready = 1'b0;
    #3;
    rst_n = 1'b0;
    #1;
    check("rst_async", {11'b0, observed()}, {11'b0, fetch_vec()});
    @(negedge clk);
    rst_n = 1'b1;
`ifdef RV32I_MC_CTRL_PERF_EN
    exp_instret = 0;
`endif
  endtask

  task automatic run_instr(input RV32I_INSTRUCTION_MNEMONIC_t mn, input RV32I_REGISTER_t rd,
                           input logic br, input int fd, input int md, input int hold);
    outs_t e;
    bit ld, st, br_i, ralu, ialu;
    ld   = mn inside {LB, LH, LW, LBU, LHU};
    st   = mn inside {SB, SH, SW};
    br_i = mn inside {BEQ, BNE, BLT, BGE, BLTU, BGEU};
    ralu = mn inside {ADD, SUB, SLL, SLT, SLTU, XOR, SRL, SRA, OR, AND};
    ialu = mn inside {ADDI, SLTI, SLTIU, XORI, ORI, ANDI, SLLI, SRLI, SRAI};
    rd_addr  = rd;
    br_taken = br;

    // The decoder output is junk while the instruction is still being fetched.
    for (int i = 0; i <= fd; i++) begin
      mnemonic = RV32I_INSTRUCTION_MNEMONIC_t'($urandom_range(0, 39));
      e = fetch_vec();
      if (i == fd && fd < TMO) begin
        e.ir_we = 1'b1;
        cyc("fetch_ready", 1'b1, e);
      end else begin
        cyc("fetch_wait", 1'b0, e);
        if (i == TMO - 1) begin
          expect_trap(2'd3, hold);
          return;
        end
      end
    end
    mnemonic = mn;

    e = '0;
    e.state = 3'd1;
    cyc("decode", rbit(), e);

    e = '0;
    e.state = 3'd2;
    if (ialu || ld || st) e.alu_b_sel = 1'b1;
    if (mn == AUIPC) begin
      e.alu_a_sel = 1'b1;
      e.alu_b_sel = 1'b1;
    end
    if (br_i) begin
      e.pc_we  = 1'b1;
      e.pc_sel = br ? 2'd1 : 2'd0;
    end
    if (mn == JAL) e.pc_sel = 2'd1;
    if (mn == JALR) e.pc_sel = 2'd2;
    cyc("exec", rbit(), e);
    if (mn == ECALL) begin expect_trap(2'd1, hold); return; end
    if (mn == EBREAK) begin expect_trap(2'd2, hold); return; end
    if (mn == NULL) begin expect_trap(2'd3, hold); return; end
    if (br_i) return;

    if (ld || st) begin
      for (int i = 0; i <= md; i++) begin
        e = '0;
        e.state        = 3'd3;
        e.mem_req      = 1'b1;
        e.addr_sel     = 1'b1;
        e.mem_we       = st;
        e.mem_size     = (mn inside {LB, LBU, SB}) ? 2'd0 : (mn inside {LH, LHU, SH}) ? 2'd1 : 2'd2;
        e.mem_unsigned = (mn inside {LBU, LHU});
        if (i == md && md < TMO) begin
          e.pc_we = st;
          cyc("mem_ready", 1'b1, e);
        end else begin
          cyc("mem_wait", 1'b0, e);
          if (i == TMO - 1) begin
            expect_trap(2'd3, hold);
            return;
          end
        end
      end
      if (st) return;
    end

    e = '0;
    e.state  = 3'd4;
    e.pc_we  = 1'b1;
    e.rf_we  = (rd != ZERO);
    e.wb_sel = ld ? 2'd1 : (mn inside {JAL, JALR}) ? 2'd2 : (mn == LUI) ? 2'd3 : 2'd0;
    if (mn == JAL) e.pc_sel = 2'd1;
    if (mn == JALR) e.pc_sel = 2'd2;
    if (!(ralu || ialu || ld || mn inside {LUI, AUIPC, JAL, JALR}))
      check("wb_unexpected_class", 32'(mn), 32'hFFFF_FFFF);
    cyc("wb", rbit(), e);
  endtask

  initial begin
    int fd, md;
    RV32I_REGISTER_t rd;
    mnemonic  = NULL;
    rd_addr   = ZERO;
    br_taken  = 1'b0;
    mem_ready = 1'b0;
    rst_n     = 1'b1;
    #2;
    rst_n = 1'b0;
    @(negedge clk);
    #1;
    check("reset_state", {11'b0, observed()}, {11'b0, fetch_vec()});
    @(negedge clk);
    rst_n = 1'b1;

    run_instr(ADD,    GP,   1'b0, 0, 0, 3);
    run_instr(LW,     T0,   1'b0, 0, 3, 3);
    run_instr(BEQ,    A0,   1'b1, 0, 0, 3);
    run_instr(BEQ,    A0,   1'b0, 0, 0, 3);
    run_instr(ADDI,   ZERO, 1'b0, 0, 0, 3);
    run_instr(SB,     A1,   1'b0, 1, 2, 3);
    run_instr(LHU,    A2,   1'b0, 0, 0, 3);
    run_instr(JALR,   RA,   1'b0, 0, 0, 3);
    run_instr(LUI,    S2,   1'b0, 0, 0, 3);
    run_instr(AUIPC,  S3,   1'b0, 0, 0, 3);
    run_instr(EBREAK, ZERO, 1'b0, 0, 0, 100);
    run_instr(ADD,    A0,   1'b0, 4, 0, 3);
    run_instr(ADD,    A0,   1'b0, 3, 0, 3);
    run_instr(SW,     A0,   1'b0, 0, 4, 3);

    for (int n = 0; n < 300; n++) begin
      rd = RV32I_REGISTER_t'($urandom_range(0, 31));
      if ($urandom_range(0, 7) == 0) rd = ZERO;
      fd = ($urandom_range(0, 9) < 7) ? 0 : int'($urandom_range(1, 4));
      md = ($urandom_range(0, 9) < 6) ? 0 : int'($urandom_range(1, 4));
      run_instr(RV32I_INSTRUCTION_MNEMONIC_t'($urandom_range(0, 39)), rd, rbit(), fd, md,
                int'($urandom_range(2, 5)));
    end

`ifdef RV32I_MC_CTRL_PERF_EN
    #1;
    check("instret_cnt", instret_cnt, 32'(exp_instret));
`endif
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
